alu_b_fwd_ctrl: RTL and testbench
=================================

Name: alu_b_fwd_ctrl

Overview:
- Control-side counterpart of the ALU operand-B select mux. Tracks destination registers through the EX/MEM/WB pipeline stages.
- Produces the registered 2-bit operand-B select for the instruction entering EX. Raises a load-use stall when no forwarding path exists.
- Sits between decode (ID) and the EX-stage operand-B mux. Keeps a saturating stall counter for performance debug.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- id_valid  input  1  valid instruction in ID
- id_rs2  input  REG_AW  operand-B source register of the ID instruction
- id_use_imm  input  1  ID instruction takes the immediate/address as operand B
- id_rd  input  REG_AW  destination register of the ID instruction
- id_wr_en  input  1  ID instruction writes id_rd
- id_is_load  input  1  ID instruction is a memory load
- ex_sel_b  output  2  registered operand-B select for the EX instruction: 00 regfile, 01 immediate, 10 fwd EX/MEM ALU result, 11 fwd MEM/WB result
- stall  output  1  combinational; hold PC and ID, bubble EX
- stall_cnt  output  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Reset (async, active-high): all stage valid bits 0, ex_sel_b=00, stall=0, stall_cnt=0. Applies immediately mid-operation; stage contents discarded.
- Stage records EX, MEM, WB each hold {valid, rd, wr_en, is_load}. A stage "writes r" when valid & wr_en & rd==r & r!=0.
- stall, combinational, asserted when all of the following hold:
  - id_valid & !id_use_imm
  - EX writes id_rs2 and EX.is_load=1
- Select decision for the ID instruction (next_sel), priority order:
  - id_use_imm → 01
  - EX writes id_rs2 (non-load) → 10
  - MEM writes id_rs2 → 11
  - otherwise 00. WB-stage matches need no forwarding: the regfile is write-first.
  - id_rs2==0 → 00 unless id_use_imm.
- Rising edge, stall=0:
  - EX <= ID fields with valid=id_valid.
  - ex_sel_b <= next_sel when id_valid, else 00.
- Rising edge, stall=1:
  - EX <= bubble (valid=0); ex_sel_b <= 00.
  - ID holds externally; the decision is re-evaluated next cycle.
- MEM<=EX and WB<=MEM every edge regardless of stall.
- Latency: ex_sel_b is valid exactly one cycle after the instruction is presented in ID with stall=0.
- stall_cnt increments on every edge where stall=1. Holds at all-ones, no wrap.
- Back-to-back loads to the same rd: each dependent consumer stalls exactly one cycle.
- Non-writing instructions (wr_en=0) never trigger forwarding or stall.

Optional Feature:
- Macro FWD_WB_EN.
- Defined: behaviour as above; select 11 is produced for MEM-stage matches.
- Undefined: select 11 is never produced. A MEM-stage match (without a higher-priority EX match) also asserts stall for one cycle. After that cycle the producer is in WB and the regfile write-first path supplies the value, giving select 00.
- The load-use rule is unchanged in both builds.

Test Plan:
- Reset mid-stream: rst=1 while EX holds a load to r3 → stall=0, ex_sel_b=00, stall_cnt=0 immediately. After release, ID rs2=3 gives ex_sel_b=00.
- Immediate bypass: ID add with id_use_imm=1, rs2=3, EX writing r3 → next cycle ex_sel_b=01, stall=0.
- EX forward: ALU op writes r5, next instruction reads rs2=5 → ex_sel_b=10. Second consumer one cycle later → 11 with FWD_WB_EN; without it, stall=1 for one cycle then ex_sel_b=00.
- Load-use: load r7 followed by a consumer of rs2=7 → stall=1 for one cycle, EX bubble, then ex_sel_b=11 (FWD_WB_EN). stall_cnt=1.
- r0 and wr_en=0: producer with rd=0, or wr_en=0 to r4; consumers rs2=0 / rs2=4 → ex_sel_b=00, no stall.
- Counter saturation: CNT_W=4, 20 forced load-use stalls → stall_cnt=15 and holds.

Source files
------------

// File: rtl/alu_b_fwd_ctrl.sv
// Operand-B forwarding control: tracks EX/MEM producers, registers the EX operand-B
// select and raises load-use stalls. Define FWD_WB_EN to enable the MEM/WB forward path (select 11).
module alu_b_fwd_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  output logic [1:0]        ex_sel_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    SEL_REG   = 2'b00,
    SEL_IMM   = 2'b01,
    SEL_EXMEM = 2'b10,
    SEL_MEMWB = 2'b11
  } sel_t;

  logic              ex_valid, ex_wr_en, ex_is_load;
  logic [REG_AW-1:0] ex_rd;
  // WB needs no record here: the write-first regfile covers it, and MEM only
  // needs enough to detect a match.
  logic              mem_valid, mem_wr_en;
  logic [REG_AW-1:0] mem_rd;

  sel_t sel_q, next_sel;
  logic ex_hit, mem_hit, need_b;

  assign need_b  = id_valid & ~id_use_imm;
  assign ex_hit  = ex_valid & ex_wr_en & (ex_rd == id_rs2) & (id_rs2 != '0);
  assign mem_hit = mem_valid & mem_wr_en & (mem_rd == id_rs2) & (id_rs2 != '0);

  always_comb begin
    stall = need_b & ex_hit & ex_is_load;
`ifndef FWD_WB_EN
    // No MEM/WB path: wait one cycle so the producer reaches the regfile.
    stall = stall | (need_b & mem_hit & ~ex_hit);
`endif
  end

  always_comb begin
    next_sel = SEL_REG;
    if (id_use_imm)   next_sel = SEL_IMM;
    else if (ex_hit)  next_sel = SEL_EXMEM;
`ifdef FWD_WB_EN
    else if (mem_hit) next_sel = SEL_MEMWB;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_wr_en   <= 1'b0;
      ex_is_load <= 1'b0;
      ex_rd      <= '0;
      mem_valid  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_rd     <= '0;
      sel_q      <= SEL_REG;
      stall_cnt  <= '0;
    end else begin
      mem_valid <= ex_valid;
      mem_wr_en <= ex_wr_en;
      mem_rd    <= ex_rd;
      ex_wr_en   <= id_wr_en;
      ex_is_load <= id_is_load;
      ex_rd      <= id_rd;
      if (stall) begin
        ex_valid <= 1'b0;
        sel_q    <= SEL_REG;
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        ex_valid <= id_valid;
        sel_q    <= id_valid ? next_sel : SEL_REG;
      end
    end
  end

  assign ex_sel_b = sel_q;

endmodule

// File: tb/tb_alu_b_fwd_ctrl.sv
// Scoreboard bench for alu_b_fwd_ctrl: a pipeline reference model pushes expected
// selects per issued instruction, popped and compared one cycle later.
module tb_alu_b_fwd_ctrl;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0, id_use_imm = 1'b0, id_wr_en = 1'b0, id_is_load = 1'b0;
  logic [REG_AW-1:0] id_rs2 = '0, id_rd = '0;
  logic [1:0]        ex_sel_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  alu_b_fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs2(id_rs2), .id_use_imm(id_use_imm),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .ex_sel_b(ex_sel_b), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit       w;
    bit       ld;
    bit [4:0] rd;
  } stage_t;

  stage_t   m_ex, m_mem;
  int       m_cnt;
  bit [1:0] sb_q[$];
  int       n_checks = 0;
  int       n_pass = 0;
  bit       last_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit writes(input stage_t s, input bit [4:0] r);
    return s.v && s.w && (s.rd == r) && (r != 0);
  endfunction

  task automatic model_reset();
    m_ex = '{default: 0};
    m_mem = '{default: 0};
    m_cnt = 0;
    sb_q.delete();
  endtask

  // One clock: present an ID instruction, check stall, then check the registered select.
  task automatic cycle(input bit v, input bit [4:0] rs2, input bit imm,
                       input bit [4:0] rd, input bit w, input bit ld);
    bit       e_stall, exw, memw, fwd;
    bit [1:0] e_sel;
    stage_t   id_s;
`ifdef FWD_WB_EN
    fwd = 1'b1;
`else
    fwd = 1'b0;
`endif
    id_valid = v; id_rs2 = rs2; id_use_imm = imm; id_rd = rd; id_wr_en = w; id_is_load = ld;
    #2;
    exw  = writes(m_ex, rs2);
    memw = writes(m_mem, rs2);
    e_stall = v && !imm && ((exw && m_ex.ld) || (!fwd && memw && !exw));
    if (imm)       e_sel = 2'b01;
    else if (exw)  e_sel = 2'b10;
    else if (memw) e_sel = fwd ? 2'b11 : 2'b00;
    else           e_sel = 2'b00;
    if (e_stall || !v) e_sel = 2'b00;
    check_eq("stall", stall, e_stall);
    sb_q.push_back(e_sel);
    last_stall = e_stall;
    @(posedge clk);
    #1;
    m_mem = m_ex;
    id_s.v = v && !e_stall; id_s.w = w; id_s.ld = ld; id_s.rd = rd;
    m_ex = id_s;
    if (e_stall && m_cnt < CNT_MAX) m_cnt++;
    if (sb_q.size() == 0) check_eq("sb_empty", 1, 0);
    else check_eq("ex_sel_b", ex_sel_b, sb_q.pop_front());
    check_eq("stall_cnt", stall_cnt, m_cnt);
  endtask

  // Re-present the ID instruction while it is stalled, with a cycle bound.
  task automatic issue(input bit [4:0] rs2, input bit imm, input bit [4:0] rd,
                       input bit w, input bit ld);
    int n = 0;
    do begin
      cycle(1, rs2, imm, rd, w, ld);
      n++;
    end while (last_stall && n < 4);
    if (last_stall) check_eq("stall_bound", 1, 0);
  endtask

  task automatic nop();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1;
    check_eq("rst_sel", ex_sel_b, 2'b00);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_cnt", stall_cnt, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Immediate bypass with EX writing r3
    issue(5'd1, 0, 5'd3, 1, 0);
    issue(5'd3, 1, 5'd9, 1, 0);
    check_eq("imm_sel", ex_sel_b, 2'b01);
    nop(); nop();

    // EX forward then second consumer (MEM match)
    issue(5'd1, 0, 5'd5, 1, 0);
    issue(5'd5, 0, 5'd0, 0, 0);
    check_eq("ex_fwd", ex_sel_b, 2'b10);
    issue(5'd5, 0, 5'd0, 0, 0);
`ifdef FWD_WB_EN
    check_eq("mem_fwd", ex_sel_b, 2'b11);
`else
    check_eq("wb_path", ex_sel_b, 2'b00);
`endif
    nop(); nop();

    // Load-use
    issue(5'd1, 0, 5'd7, 1, 1);
    issue(5'd7, 0, 5'd0, 0, 0);
    check_eq("lu_cnt_nz", stall_cnt != 0, 1);
    nop(); nop();

    // r0 producer and non-writing producer
    issue(5'd1, 0, 5'd0, 1, 1);
    issue(5'd0, 0, 5'd0, 0, 0);
    check_eq("r0_sel", ex_sel_b, 2'b00);
    issue(5'd1, 0, 5'd4, 0, 1);
    issue(5'd4, 0, 5'd0, 0, 0);
    check_eq("nowr_sel", ex_sel_b, 2'b00);
    nop(); nop();

    // Reset mid-stream with a load to r3 in EX
    issue(5'd1, 0, 5'd3, 1, 1);
    id_valid = 1; id_rs2 = 5'd3; id_use_imm = 0; id_rd = 0; id_wr_en = 0; id_is_load = 0;
    #2;
    check_eq("pre_rst_stall", stall, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_stall", stall, 0);
    check_eq("mid_rst_sel", ex_sel_b, 2'b00);
    check_eq("mid_rst_cnt", stall_cnt, 0);
    id_valid = 0;
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue(5'd3, 0, 5'd0, 0, 0);
    check_eq("post_rst_sel", ex_sel_b, 2'b00);

    // Random mix over a small register set
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) nop();
      else issue(5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0));
    end
    nop(); nop();

    // Counter saturation via repeated load-use
    for (int i = 0; i < 20; i++) begin
      issue(5'd1, 0, 5'd7, 1, 1);
      issue(5'd7, 0, 5'd0, 0, 0);
      nop(); nop();
    end
    check_eq("cnt_sat", stall_cnt, CNT_MAX);
    nop();
    check_eq("cnt_hold", stall_cnt, CNT_MAX);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
